draw_projectile: RTL
====================

# draw_projectile

Pipeline stage placed directly downstream of `draw_cat` in the VGA chain. It consumes `draw_cat`'s `vga_if` stream and overlays a square projectile thrown by the cat. The projectile's ballistic trajectory is integrated once per frame. It passes all timing signals through with one clock of latency and reports landing to the game logic.

## Interface
Parameters:
- `START_X`, 100, launch x (pixels).
- `START_Y`, 400, launch y (pixels).
- `SIZE`, 8, projectile edge length (pixels).
- `VY0`, 12, initial upward speed (pixels/frame).
- `GRAVITY`, 1, vy increment per frame.
- `GROUND_Y`, 560, landing line for projectile top edge.
- `LAND_FRAMES`, 30, frames the landed projectile stays visible.
- `COLOR`, 12'hF80, projectile RGB.

Ports:
- `clk60MHz` in, 1: the block's one clock.
- `rst` in, 1: asynchronous, active-high reset.
- `throw` in, 1: launch request, sampled every cycle.
- `power` in, 7: horizontal speed vx (pixels/frame, unsigned).
- `busy` out, 1: high in FLIGHT or LANDED.
- `hit` out, 1: one-cycle pulse on landing.
- `in` vga_if.in: upstream timing and rgb from `draw_cat`.
- `out` vga_if.out: registered timing and rgb.

## Operation
- State machine: IDLE, FLIGHT, LANDED.
- **IDLE**:
  - `throw`=1 goes to FLIGHT on the next edge.
  - Loads x=START_X, y=START_Y, vx=power, vy=−VY0.
  - frame_cnt=0.
- **FLIGHT**: `throw` is ignored. On each frame tick:
  - x_n=x+vx, y_n=y+vy, vy+=GRAVITY.
  - If x_n>1023: go to IDLE with no hit (off-screen). This check has priority over landing.
  - Else if y_n≥GROUND_Y: y=GROUND_Y, x=x_n, go to LANDED, and pulse `hit` for one cycle.
  - Else: x=x_n, y=y_n.
- **LANDED**:
  - frame_cnt increments on each frame tick.
  - When frame_cnt reaches LAND_FRAMES−1 on a tick, go to IDLE.
  - `throw` is ignored.
- Frame tick: the rising edge of `in.vblnk`, detected against a registered copy. Position therefore changes only during blanking, so there is no tearing.
- Widths:
  - x is 11-bit unsigned.
  - y is 12-bit signed.
  - vy is 8-bit signed.
  - Comparisons sign-extend hcount/vcount.
- Drawing: projectile pixel when all of the following hold, in which case rgb_nxt=COLOR; otherwise rgb_nxt=in.rgb:
  - state ≠ IDLE;
  - in.vblnk=0 and in.hblnk=0;
  - x ≤ hcount < x+SIZE;
  - y ≤ vcount < y+SIZE.
- Rows with negative y are not drawn.

## Timing
- Latency is exactly 1 cycle. All `out` timing fields are `in` delayed by one register. `out.rgb` is the registered rgb_nxt.
- Reset values:
  - all `out` fields 0;
  - state IDLE;
  - `busy`=0, `hit`=0;
  - x, y, vx, vy, frame_cnt all 0.
- `busy` is registered and changes on the same edge as the state.
- `hit` is high for exactly the cycle after the landing tick edge.
- Reset asserted mid-flight returns to IDLE immediately. The projectile is not drawn from the next output cycle, and no `hit` is produced.
- `throw` and a frame tick arriving on the same cycle in IDLE: the launch wins. The first integration happens at the next tick.

## Configuration
- Macro `DRAW_PROJECTILE_OUTLINE_EN`.
- Defined: the outermost 1-pixel ring of the projectile square is drawn as 12'h000 and the interior as COLOR.
- Undefined: the whole square is drawn as COLOR.
- Timing and latency are identical in both builds.

## Test plan
- **Reset**: assert `rst` asynchronously mid-line → all `out` fields 0, `busy`=0, `hit`=0, with no clock needed.
- **Passthrough**: IDLE, random in.rgb/hcount/vcount → `out` equals `in` delayed 1 cycle; rgb unchanged.
- **Normal flight**: throw with power=10 →
  - after 25 ticks, y=400 and x=350;
  - landing on tick 35 with x=450, y=560;
  - one `hit` pulse;
  - `busy` high until 30 ticks later.
- **Off-screen**: throw with power=127 → tick 8 gives x_n=1116, so the block goes to IDLE; no `hit`, and `busy` drops.
- **Drawing**: during flight with x=110, y=388, scan the frame →
  - exactly an 8×8 block of 12'hF80 at (110..117, 388..395);
  - with the outline macro: ring pixels 12'h000 and 6×6 interior 12'hF80.
- **Ignored requests**: throw pulses in FLIGHT and in LANDED → trajectory unchanged, and no relaunch until IDLE.

Source files
------------

// File: rtl/draw_projectile_if.sv
// rtl/draw_projectile_if.sv - VGA timing and pixel bundle passed between draw stages
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_projectile.sv
// rtl/draw_projectile.sv - ballistic projectile overlay stage, one-cycle VGA passthrough
// Optional DRAW_PROJECTILE_OUTLINE_EN: draws a black 1-pixel ring around the projectile.
module draw_projectile #(
  parameter int          START_X     = 100,
  parameter int          START_Y     = 400,
  parameter int          SIZE        = 8,
  parameter int          VY0         = 12,
  parameter int          GRAVITY     = 1,
  parameter int          GROUND_Y    = 560,
  parameter int          LAND_FRAMES = 30,
  parameter logic [11:0] COLOR       = 12'hF80
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       throw,
  input  logic [6:0] power,
  output logic       busy,
  output logic       hit,
  vga_if.in          in,
  vga_if.out         out
);
  typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} state_t;
  localparam int                 CW       = $clog2(LAND_FRAMES) + 1;
  localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);
  localparam logic signed [12:0] SIZE_S   = 13'(SIZE);

  state_t                r_state, w_state_nxt;
  logic [10:0]           r_x;
  logic signed [11:0]    r_y;
  logic [6:0]            r_vx;
  logic signed [7:0]     r_vy;
  logic [CW-1:0]         r_frame_cnt;
  logic                  r_vblnk_d;
  logic                  w_tick, w_offscreen, w_landing, w_land_done;
  logic                  w_busy_nxt, w_hit_nxt;
  logic [11:0]           w_x_n;
  logic signed [11:0]    w_y_n;
  logic signed [12:0]    w_hc, w_vc, w_x0, w_y0, w_x1, w_y1;
  logic                  w_in_box;
  logic [11:0]           w_rgb_nxt;

  // Frame tick on the rising edge of vblnk, so positions only move during blanking
  assign w_tick      = in.vblnk & ~r_vblnk_d;
  assign w_x_n       = {1'b0, r_x} + {5'd0, r_vx};
  assign w_y_n       = r_y + {{4{r_vy[7]}}, r_vy};
  assign w_offscreen = (w_x_n > 12'd1023);
  assign w_landing   = (w_y_n >= GROUND_S);
  assign w_land_done = (r_frame_cnt == CW'(LAND_FRAMES - 1));

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      busy      <= 1'b0;
      hit       <= 1'b0;
      r_vblnk_d <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      busy      <= w_busy_nxt;
      hit       <= w_hit_nxt;
      r_vblnk_d <= in.vblnk;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (throw) w_state_nxt = FLIGHT;
      FLIGHT:  if (w_tick) begin
                 if (w_offscreen)    w_state_nxt = IDLE;
                 else if (w_landing) w_state_nxt = LANDED;
               end
      LANDED:  if (w_tick && w_land_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = (w_state_nxt != IDLE);
    w_hit_nxt  = (r_state == FLIGHT) && w_tick && !w_offscreen && w_landing;
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_vx        <= '0;
      r_vy        <= '0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (throw) begin
          r_x         <= 11'(START_X);
          r_y         <= 12'(START_Y);
          r_vx        <= power;
          r_vy        <= 8'(-VY0);
          r_frame_cnt <= '0;
        end
        FLIGHT: if (w_tick) begin
          r_vy <= r_vy + 8'(GRAVITY);
          if (!w_offscreen) begin
            r_x <= w_x_n[10:0];
            r_y <= w_landing ? GROUND_S : w_y_n;
          end
        end
        LANDED: if (w_tick && !w_land_done) r_frame_cnt <= r_frame_cnt + CW'(1);
        default: ;
      endcase
    end
  end

  assign w_hc     = $signed({2'b00, in.hcount});
  assign w_vc     = $signed({2'b00, in.vcount});
  assign w_x0     = $signed({2'b00, r_x});
  assign w_y0     = {r_y[11], r_y};
  assign w_x1     = w_x0 + SIZE_S - 13'sd1;
  assign w_y1     = w_y0 + SIZE_S - 13'sd1;
  assign w_in_box = (r_state != IDLE) && !in.vblnk && !in.hblnk &&
                    (w_hc >= w_x0) && (w_hc <= w_x1) &&
                    (w_vc >= w_y0) && (w_vc <= w_y1);

`ifdef DRAW_PROJECTILE_OUTLINE_EN
  logic w_ring;
  assign w_ring    = (w_hc == w_x0) || (w_hc == w_x1) || (w_vc == w_y0) || (w_vc == w_y1);
  assign w_rgb_nxt = !w_in_box ? in.rgb : (w_ring ? 12'h000 : COLOR);
`else
  assign w_rgb_nxt = w_in_box ? COLOR : in.rgb;
`endif

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= in.vcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.hcount <= in.hcount;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.rgb    <= w_rgb_nxt;
    end
  end
endmodule
